input_source_arbiter: RTL

- Per-player arbiter that shares each paddle between two command sources: debounced pushbuttons and the UART keyboard/controller stream.
- In auto mode, whichever source shows activity first takes ownership of a player's paddle, and keeps it until that source goes quiet for IDLE_CYCLES.
- Also acts as a stuck-key watchdog for UART, where a lost release byte would otherwise hold a paddle forever.
- Sits between the input front end (debouncer, UART decoder) and the paddle motion logic.

---
 rtl/input_source_arbiter_pkg.sv | 26 ++
 rtl/input_source_arbiter_if.sv | 24 ++
 rtl/input_source_arbiter_player.sv | 121 ++++++++++++
 rtl/input_source_arbiter.sv | 51 +++++
 4 files changed

// File: rtl/input_source_arbiter_pkg.sv
// Shared encodings for the paddle input-source arbiter: mode codes, owner/state
// codes and default idle timeout.
package input_source_arbiter_pkg;

  typedef enum logic [1:0] {
    MODE_BTN  = 2'd0,
    MODE_UART = 2'd1,
    MODE_AUTO = 2'd2,
    MODE_OFF  = 2'd3
  } mode_e;

  // Owner codes double as the per-player FSM state codes.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BTN  = 2'd1,
    SRC_UART = 2'd2
  } src_e;

  localparam int unsigned IDLE_CYCLES_DEF = 32'd50000000;
  localparam int unsigned CNT_W_DEF       = 32'd26;

  function automatic logic [1:0] cancel_conflict(input logic [1:0] pair);
    return (pair == 2'b11) ? 2'b00 : pair;
  endfunction

endpackage

// File: rtl/input_source_arbiter_if.sv
// Bundle of command inputs and paddle outputs between the input front end and
// the paddle motion logic.
interface input_source_arbiter_if;
  logic [1:0] mode;
  logic [3:0] btn_cmd;
  logic [3:0] uart_cmd;
  logic [1:0] uart_evt;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic [1:0] p1_src;
  logic [1:0] p2_src;

  modport master (
    output mode, btn_cmd, uart_cmd, uart_evt,
    input  p1_up, p1_down, p2_up, p2_down, p1_src, p2_src
  );

  modport slave (
    input  mode, btn_cmd, uart_cmd, uart_evt,
    output p1_up, p1_down, p2_up, p2_down, p1_src, p2_src
  );
endinterface

// File: rtl/input_source_arbiter_player.sv
// One player's ownership FSM with idle/stuck-key timeout, source pair select
// and up+down cancel; outputs registered one cycle after the inputs.
module player_owner_fsm
  import input_source_arbiter_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES  = IDLE_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned BTN_PRIORITY = 32'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  mode_e      mode,
  input  logic [1:0] btn_pair,
  input  logic [1:0] uart_pair,
  input  logic       uart_evt,
  output logic       up,
  output logic       down,
  output logic [1:0] src
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic             BTN_WINS = (BTN_PRIORITY != 32'd0);

  src_e             state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             btn_act_s;
  logic [1:0]       pair_s;
  src_e             src_s;
  logic             up_r, down_r;
  src_e             src_r;

  assign btn_act_s = |btn_pair;

  // Ownership next-state and idle counter; the counter stops at CNT_LAST.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (mode != MODE_AUTO) begin
      state_s = SRC_NONE;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        SRC_NONE: begin
          cnt_s = CNT_ZERO;
          if (btn_act_s && (!uart_evt || BTN_WINS)) begin
            state_s = SRC_BTN;
          end else if (uart_evt) begin
            state_s = SRC_UART;
          end else begin
            state_s = SRC_NONE;
          end
        end
        SRC_BTN, SRC_UART: begin
          if ((state_r == SRC_BTN) ? btn_act_s : uart_evt) begin
            cnt_s = CNT_ZERO;
          end else if (cnt_r >= CNT_LAST) begin
            state_s = SRC_NONE;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = SRC_NONE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Command pair and owner code, taken from the next state so the output lags inputs by one edge.
  always_comb begin
    pair_s = 2'b00;
    src_s  = SRC_NONE;
    case (mode)
      MODE_BTN: begin
        pair_s = btn_pair;
        src_s  = SRC_BTN;
      end
      MODE_UART: begin
        pair_s = uart_pair;
        src_s  = SRC_UART;
      end
      MODE_AUTO: begin
        src_s = state_s;
        case (state_s)
          SRC_BTN:  pair_s = btn_pair;
          SRC_UART: pair_s = uart_pair;
          default:  pair_s = 2'b00;
        endcase
      end
      default: begin
        pair_s = 2'b00;
        src_s  = SRC_NONE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= SRC_NONE;
      cnt_r   <= CNT_ZERO;
      up_r    <= 1'b0;
      down_r  <= 1'b0;
      src_r   <= SRC_NONE;
    end else begin
      state_r          <= state_s;
      cnt_r            <= cnt_s;
      {down_r, up_r}   <= cancel_conflict(pair_s);
      src_r            <= src_s;
    end
  end

  assign up   = up_r;
  assign down = down_r;
  assign src  = src_r;

endmodule

// File: rtl/input_source_arbiter.sv
// Per-player paddle arbiter between debounced buttons and the UART command
// stream; decodes mode and slices the per-player command bits.
module input_source_arbiter
  import input_source_arbiter_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES  = IDLE_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned BTN_PRIORITY = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input_source_arbiter_if.slave bus
);

  mode_e mode_s;

  assign mode_s = mode_e'(bus.mode);

  player_owner_fsm #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .CNT_W       (CNT_W),
    .BTN_PRIORITY(BTN_PRIORITY)
  ) u_p1 (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode_s),
    .btn_pair (bus.btn_cmd[1:0]),
    .uart_pair(bus.uart_cmd[1:0]),
    .uart_evt (bus.uart_evt[0]),
    .up       (bus.p1_up),
    .down     (bus.p1_down),
    .src      (bus.p1_src)
  );

  player_owner_fsm #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .CNT_W       (CNT_W),
    .BTN_PRIORITY(BTN_PRIORITY)
  ) u_p2 (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode_s),
    .btn_pair (bus.btn_cmd[3:2]),
    .uart_pair(bus.uart_cmd[3:2]),
    .uart_evt (bus.uart_evt[1]),
    .up       (bus.p2_up),
    .down     (bus.p2_down),
    .src      (bus.p2_src)
  );

endmodule
